// File: rtl/sig_menu_ctrl_if.sv
// Front-panel bundle between the button/menu controller and its surroundings:
// raw active-low keys in, committed generator settings and menu status out.
interface sig_menu_ctrl_if;
   logic [3:0] key_in;
   logic [1:0] cnt_sig;
   logic [1:0] cnt_amp;
   logic [1:0] cnt_fre;
   logic [1:0] cnt_phase;
   logic       confirm;
   logic [1:0] sel_field;
   logic       dirty;

   modport master (
      output key_in,
      input  cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, sel_field, dirty
   );

   modport slave (
      input  key_in,
      output cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, sel_field, dirty
   );
endinterface

// File: rtl/sig_menu_ctrl.sv
// Debounces four front-panel buttons and runs a select/edit/confirm menu whose
// shadow settings are committed to the waveform generator only on confirm.
module sig_menu_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic           clk,
   input  logic           rst,
   sig_menu_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [0:0] ST_STOP = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [3:0]       s1;
   logic [3:0]       s2;
   logic [3:0]       level;
   logic [3:0]       level_d;
   logic [3:0]       press;
   logic [CNT_W-1:0] db_cnt [4];

   logic [3:0][1:0]  shadow;
   logic [3:0][1:0]  committed;
   logic [1:0]       sel_field;
   logic [0:0]       state;
   logic             dirty;

   logic ev_confirm;
   logic ev_select;
   logic ev_inc;
   logic ev_dec;

   // A key level is accepted only after s2 has disagreed with it for
   // DEBOUNCE_CYCLES consecutive cycles; a press is an accepted 1->0 edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '1;
         s2      <= '1;
         level   <= '1;
         level_d <= '1;
         press   <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         s1      <= bus.key_in;
         s2      <= s1;
         level_d <= level;
         press   <= level_d & ~level;
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               level[i]  <= s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      ev_confirm = press[3];
      ev_select  = press[0] & ~press[3];
      ev_inc     = press[1] & ~press[3] & ~press[0];
      ev_dec     = press[2] & ~press[3] & ~press[0] & ~press[1];
   end

   // A commit makes committed equal to shadow, so dirty clears on that same
   // edge; every other change shows up in dirty one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_STOP;
         sel_field <= 2'd0;
         shadow    <= {2'd0, 2'd0, 2'd1, 2'd0};
         committed <= {2'd0, 2'd0, 2'd1, 2'd0};
         dirty     <= 1'b0;
      end else begin
         dirty <= (shadow != committed);
         if (ev_confirm) begin
            if (state == ST_STOP) begin
               committed <= shadow;
               state     <= ST_RUN;
               dirty     <= 1'b0;
            end else begin
               state <= ST_STOP;
            end
         end else if (ev_select) begin
            sel_field <= sel_field + 2'd1;
         end else if (ev_inc) begin
            shadow[sel_field] <= shadow[sel_field] + 2'd1;
         end else if (ev_dec) begin
            shadow[sel_field] <= shadow[sel_field] - 2'd1;
         end
      end
   end

   assign bus.cnt_sig   = committed[0];
   assign bus.cnt_amp   = committed[1];
   assign bus.cnt_fre   = committed[2];
   assign bus.cnt_phase = committed[3];
   assign bus.confirm   = (state == ST_RUN);
   assign bus.sel_field = sel_field;
   assign bus.dirty     = dirty;

endmodule

// File: tb/tb_sig_menu_ctrl.sv
// Bench for sig_menu_ctrl: directed latency/priority/reset steps followed by
// random key presses, all compared against an event-level menu model.
module tb_sig_menu_ctrl;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   int   m_shadow [4];
   int   m_cnt    [4];
   bit   m_run;
   int   m_sel;

   sig_menu_ctrl_if bus ();

   sig_menu_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_shadow = '{0, 1, 0, 0};
      m_cnt    = '{0, 1, 0, 0};
      m_run    = 1'b0;
      m_sel    = 0;
   endtask

   // One operator action: the highest-priority key of the group wins.
   task automatic model_event(input logic [3:0] mask);
      if (mask[3]) begin
         if (!m_run) begin
            m_cnt = m_shadow;
            m_run = 1'b1;
         end else begin
            m_run = 1'b0;
         end
      end else if (mask[0]) begin
         m_sel = (m_sel + 1) % 4;
      end else if (mask[1]) begin
         m_shadow[m_sel] = (m_shadow[m_sel] + 1) % 4;
      end else if (mask[2]) begin
         m_shadow[m_sel] = (m_shadow[m_sel] + 3) % 4;
      end
   endtask

   function automatic bit model_dirty();
      bit d = 1'b0;
      for (int i = 0; i < 4; i++) if (m_shadow[i] != m_cnt[i]) d = 1'b1;
      return d;
   endfunction

   task automatic check_all(input string tag);
      check_output({tag, ".sig"},   8'(bus.cnt_sig),   8'(m_cnt[0]));
      check_output({tag, ".amp"},   8'(bus.cnt_amp),   8'(m_cnt[1]));
      check_output({tag, ".fre"},   8'(bus.cnt_fre),   8'(m_cnt[2]));
      check_output({tag, ".phase"}, 8'(bus.cnt_phase), 8'(m_cnt[3]));
      check_output({tag, ".confirm"}, 8'(bus.confirm), 8'(m_run));
      check_output({tag, ".sel"},   8'(bus.sel_field), 8'(m_sel));
      check_output({tag, ".dirty"}, 8'(bus.dirty),     8'(model_dirty()));
   endtask

   task automatic apply_stimulus(input logic [3:0] mask, input int hold);
      bus.key_in = ~mask;
      tick(hold);
      bus.key_in = 4'hF;
      tick(12);
   endtask

   initial begin
      logic [3:0] mask;

      rst        = 1'b1;
      bus.key_in = 4'hF;
      model_reset();
      tick(3);
      check_all("reset");
      rst = 1'b0;
      tick(2);
      check_all("post_reset");

      // Held inc: shadow changes at edge DB+4, dirty follows one edge later.
      bus.key_in = 4'b1101;
      tick(DB + 4);
      check_output("inc_dirty_early", 8'(bus.dirty), 8'd0);
      tick(1);
      check_output("inc_dirty_late", 8'(bus.dirty), 8'd1);
      check_output("inc_cnt_sig", 8'(bus.cnt_sig), 8'd0);
      model_event(4'b0010);
      tick(15);
      check_all("inc_held");
      bus.key_in = 4'hF;
      tick(12);

      bus.key_in = 4'b1101;
      tick(DB - 1);
      bus.key_in = 4'hF;
      tick(12);
      check_all("glitch");

      apply_stimulus(4'b0001, 6);
      model_event(4'b0001);
      apply_stimulus(4'b0001, 6);
      model_event(4'b0001);
      apply_stimulus(4'b0100, 6);
      model_event(4'b0100);
      check_all("edit");

      bus.key_in = 4'b0111;
      tick(DB + 3);
      check_output("commit_early", 8'(bus.confirm), 8'd0);
      tick(1);
      model_event(4'b1000);
      check_all("commit");
      bus.key_in = 4'hF;
      tick(12);

      apply_stimulus(4'b0010, 6);
      model_event(4'b0010);
      check_all("run_edit");
      apply_stimulus(4'b1000, 6);
      model_event(4'b1000);
      check_all("stop");
      apply_stimulus(4'b1000, 6);
      model_event(4'b1000);
      check_all("recommit");

      apply_stimulus(4'b1010, 6);
      model_event(4'b1010);
      check_all("inc_confirm");
      apply_stimulus(4'b0101, 6);
      model_event(4'b0101);
      check_all("select_dec");

      // Reset lands mid-debounce with confirm still held down.
      bus.key_in = 4'b0111;
      tick(2);
      rst = 1'b1;
      tick(2);
      model_reset();
      check_all("rst_mid");
      rst = 1'b0;
      tick(DB + 3);
      check_output("held_early", 8'(bus.confirm), 8'd0);
      tick(1);
      model_event(4'b1000);
      check_all("held_commit");
      tick(20);
      check_all("held_norepeat");
      bus.key_in = 4'hF;
      tick(12);
      check_all("held_release");

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) < 7) mask = 4'(1 << $urandom_range(0, 3));
         else mask = 4'($urandom_range(1, 15));
         apply_stimulus(mask, int'($urandom_range(5, 12)));
         model_event(mask);
         check_all("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sig_menu_ctrl.md
# sig_menu_ctrl

Front-panel control stage that sits directly upstream of the waveform generator. It debounces four raw push-buttons and runs a field-select/edit menu. It drives the generator's `cnt_sig`, `cnt_amp`, `cnt_fre`, `cnt_phase` and `confirm` inputs. Edits go into shadow registers and reach the generator only on a confirm press, so the generator never sees half-edited settings.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a key level (20 ms at 50 MHz); minimum 1.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock (same clock as the generator).
- `rst`  in  1  reset, synchronous, active-high.
- `key_in`  in  4  raw buttons, active-low (0 = pressed); asynchronous to `clk`. [0]=select, [1]=inc, [2]=dec, [3]=confirm.
- `cnt_sig`  out  2  committed waveform: 0 sin, 1 square, 2 triangle, 3 saw.
- `cnt_amp`  out  2  committed amplitude code.
- `cnt_fre`  out  2  committed frequency code.
- `cnt_phase`  out  2  committed phase/duty code.
- `confirm`  out  1  generator run enable.
- `sel_field`  out  2  field currently being edited: 0 sig, 1 amp, 2 fre, 3 phase.
- `dirty`  out  1  shadow settings differ from committed settings.

## Operation
- **Per-key front end:** 2-flop synchronizer (`s1`, `s2`), then a debounce counter.
  - Counter clears whenever `s2` equals the accepted level.
  - While they differ, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ: accepted level <= `s2` and the counter clears.
  - A press pulse (1 cycle, registered) fires on an accepted 1→0 transition. Releases produce no event.
- **Event arbitration:** at most one event is acted on per cycle. Priority is confirm > select > inc > dec. Lower-priority pulses in the same cycle are discarded, not queued.
- **Select:** `sel_field` <= `sel_field`+1, wrapping 3→0.
- **Inc:** the shadow field indexed by `sel_field` increments, wrapping 3→0.
- **Dec:** the shadow field indexed by `sel_field` decrements, wrapping 0→3.
- Shadow fields are editable in both states. Committed outputs never change on select, inc or dec.
- **State machine (2 states):**
  - STOP (`confirm`=0), confirm event: copy all four shadows to `cnt_*`, set `confirm`=1, go to RUN.
  - RUN (`confirm`=1), confirm event: set `confirm`=0, go to STOP. `cnt_*` hold their values.
  - To apply new edits while running, the operator presses confirm twice (stop, then commit).
- **`dirty`:** registered; equals 1 when any shadow field differs from the corresponding `cnt_*`.
- **Reset values:**
  - `cnt_sig`=0, `cnt_amp`=1, `cnt_fre`=0, `cnt_phase`=0. Shadows take the same values.
  - `confirm`=0, state STOP, `sel_field`=0, `dirty`=0.
  - Sync flops and accepted levels = 1 (released); debounce counters = 0; press pulses = 0.
- **Reset mid-operation:** all of the above is restored on the next edge, and any debounce in progress is abandoned. A key held through reset is seen as a new press one debounce interval after `rst` falls.

## Timing
- **Press latency:** the raw level first changes before edge 1. The accepted level changes at edge DEBOUNCE_CYCLES+2, the pulse is high after edge DEBOUNCE_CYCLES+3, and shadow/`sel_field`/`cnt_*`/`confirm` update at edge DEBOUNCE_CYCLES+4.
- `dirty` updates one edge after the shadow or committed change that causes it.
- **Bounce:** any return of `s2` to the accepted level restarts the count from 0. A glitch shorter than DEBOUNCE_CYCLES produces no event.
- **Auto-repeat:** none. A held key gives exactly one event. The next event requires an accepted release followed by a new accepted press.
- All outputs are registered. There are no combinational paths from `key_in` to any output.

## Test plan
(DEBOUNCE_CYCLES=4 throughout.)
1. **Reset:** assert `rst` 3 cycles with `key_in`=4'hF. Required: `cnt_amp`=1, all other `cnt_*`=0, `confirm`=0, `sel_field`=0, `dirty`=0.
2. **Debounce latency and glitch rejection:**
   - Hold `key_in[1]` low. Required: shadow sig = 1 at edge 8 and `dirty`=1 at edge 9. `cnt_sig` stays 0.
   - A 3-cycle low glitch on `key_in[1]` produces no change.
3. **Edit and commit:**
   - Select ×2 (`sel_field`=2), then dec ×1: shadow fre goes 0→3 (wrap).
   - Confirm: required `cnt_fre`=3, `confirm`=1, `dirty`=0 on the same edge as `confirm`.
4. **Edit while running:**
   - In RUN, inc on `sel_field`=2: `cnt_fre` stays 3, `dirty`=1.
   - Confirm: `confirm`=0, `cnt_fre` still 3.
   - Confirm again: `cnt_fre`=0, `confirm`=1.
5. **Simultaneous presses:** drive inc and confirm low on the same cycle. Required: only the confirm action occurs and the shadow is unchanged. Select+dec together: only `sel_field` advances.
6. **Reset mid-debounce and held key:** assert `rst` two cycles into a confirm debounce, keep the key held, then release `rst`. Required: all reset values, then one confirm event (`confirm`=1) exactly DEBOUNCE_CYCLES+4 edges after `rst` deasserts, and no further events while held.
